// File: rtl/uart_pkg.sv
// Shared types for the UART stream model: frame options, engine states,
// the RX FIFO entry layout and the parity helper used by both engines.
package uart_pkg;

  localparam int MAX_DATA_BITS = 8;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  // Narrow payloads are zero-extended, which leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] d,
                                       input parity_e p);
    return (p == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head, full/empty from pointers that
// carry an extra wrap bit. A push into an empty FIFO appears at the head next cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = head_q;

  // The incoming word lands on the head slot only when the FIFO is empty after
  // this cycle's pop; a full FIFO never reaches here because the push is refused.
  always_comb begin
    wr_d   = wr_q + {{AW{1'b0}}, do_push};
    rd_d   = rd_q + {{AW{1'b0}}, do_pop};
    head_d = mem_q[rd_d[AW-1:0]];
    if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) head_d = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/uart_stream_model.sv
// UART model between a serial pin pair and host valid/ready streams: TX FIFO
// feeding a bit engine on txd, rxd synchroniser and bit engine feeding an RX FIFO.
module uart_stream_model
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ  = 70_000_000,
  parameter int      BAUD      = 115200,
  parameter int      DATA_BITS = 8,
  parameter parity_e PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1,
  parameter int      TX_DEPTH  = 16,
  parameter int      RX_DEPTH  = 16,
  parameter int      VERBOSE   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic                 txd,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overflow,
  input  logic                 overflow_clr
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = $clog2(2 * CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $fatal(1, "uart_stream_model: DATA_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $fatal(1, "uart_stream_model: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 8) begin : g_bad_baud
    $fatal(1, "uart_stream_model: CLK_FREQ/BAUD must be >= 8");
  end
  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx_depth
    $fatal(1, "uart_stream_model: TX_DEPTH must be a power of two >= 2");
  end
  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
    $fatal(1, "uart_stream_model: RX_DEPTH must be a power of two >= 2");
  end
  if (VERBOSE != 0 && VERBOSE != 1) begin : g_bad_verbose
    $fatal(1, "uart_stream_model: VERBOSE must be 0 or 1");
  end

  // ---------------------------------------------------------------- TX side
  logic [DATA_BITS-1:0] txf_head;
  logic                 txf_full, txf_empty, tx_pop;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (tx_valid),
    .wdata_i(tx_data),
    .pop_i  (tx_pop),
    .head_o (txf_head),
    .full_o (txf_full),
    .empty_o(txf_empty)
  );

  tx_state_e            tx_st_q;
  logic                 tx_go_q, tx_par_q, txd_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [BW-1:0]        tx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q;

  // tx_go_q marks the one-cycle gap between popping a byte from idle and the
  // start bit; back-to-back frames skip it by loading straight out of STOP.
  always_comb begin
    tx_pop = 1'b0;
    if (tx_st_q == TX_IDLE && !tx_go_q && !txf_empty) tx_pop = 1'b1;
    if (tx_st_q == TX_STOP && tx_cnt_q == STOP_LAST && !txf_empty) tx_pop = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q  <= TX_IDLE;
      tx_go_q  <= 1'b0;
      tx_par_q <= 1'b0;
      txd_q    <= 1'b1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
    end else begin
      if (tx_pop) begin
        tx_sh_q  <= txf_head;
        tx_par_q <= calc_parity(MAX_DATA_BITS'(txf_head), PARITY);
      end
      case (tx_st_q)
        TX_IDLE: begin
          if (tx_go_q) begin
            tx_go_q  <= 1'b0;
            tx_st_q  <= TX_START;
            tx_cnt_q <= '0;
            txd_q    <= 1'b0;
          end else if (tx_pop) begin
            tx_go_q <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            txd_q    <= tx_sh_q[0];
            tx_st_q  <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == DATA_LAST) begin
              if (PARITY != PAR_NONE) begin
                tx_st_q <= TX_PARITY;
                txd_q   <= tx_par_q;
              end else begin
                tx_st_q <= TX_STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              tx_sh_q  <= tx_sh_q >> 1;
              txd_q    <= tx_sh_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_PARITY: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            tx_st_q  <= TX_STOP;
            txd_q    <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == STOP_LAST) begin
            tx_cnt_q <= '0;
            if (tx_pop) begin
              tx_st_q <= TX_START;
              txd_q   <= 1'b0;
            end else begin
              tx_st_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: begin
          tx_st_q <= TX_IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign tx_ready = !txf_full;
  assign tx_busy  = !txf_empty || tx_go_q || (tx_st_q != TX_IDLE);

  // ---------------------------------------------------------------- RX side
  rx_state_e            rx_st_q;
  logic                 rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic                 rx_perr_q, rx_ovf_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [BW-1:0]        rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_stop_smp, rx_drop;
  logic                 rxf_full, rxf_empty;
  rx_entry_t            rx_wr, rx_head;

  assign rx_stop_smp = (rx_st_q == RX_STOP) && (rx_cnt_q == BIT_LAST);
  assign rx_drop     = rx_stop_smp && rxf_full;
  assign rx_wr       = '{frame_err:  !rxd_s2_q,
                         parity_err: rx_perr_q,
                         data:       MAX_DATA_BITS'(rx_sh_q)};

  uart_sync_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (rx_stop_smp),
    .wdata_i(rx_wr),
    .pop_i  (rx_ready),
    .head_o (rx_head),
    .full_o (rxf_full),
    .empty_o(rxf_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_perr_q  <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      if (rx_drop)           rx_ovf_q <= 1'b1;
      else if (overflow_clr) rx_ovf_q <= 1'b0;
      case (rx_st_q)
        RX_IDLE: begin
          if (rxd_prev_q && !rxd_s2_q) begin
            rx_st_q  <= RX_START;
            rx_cnt_q <= '0;
          end
        end
        RX_START: begin
          // Half a bit in: a line back high was a glitch, otherwise lock onto mid-bit.
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q <= '0;
            if (rxd_s2_q) begin
              rx_st_q <= RX_IDLE;
            end else begin
              rx_st_q   <= RX_DATA;
              rx_bit_q  <= '0;
              rx_perr_q <= 1'b0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rxd_s2_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q == DATA_LAST)
              rx_st_q <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            else
              rx_bit_q <= rx_bit_q + 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q  <= '0;
            rx_perr_q <= rxd_s2_q != calc_parity(MAX_DATA_BITS'(rx_sh_q), PARITY);
            rx_st_q   <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            rx_st_q  <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_valid      = !rxf_empty;
  assign rx_data       = rx_head.data[DATA_BITS-1:0];
  assign rx_parity_err = rx_head.parity_err;
  assign rx_frame_err  = rx_head.frame_err;
  assign rx_overflow   = rx_ovf_q;

endmodule

// File: tb/tb_uart_stream_model.sv
// Directed bench: three model instances (8N1 depth-4 loopback/injection, 7E2
// loopback, 8O1 driven rxd) with a scoreboard queue of expected RX entries.
module tb_uart_stream_model;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [9:0] sb[$];

  // instance A: 8N1, RX_DEPTH 4, rxd from txd or injected
  logic       a_txd, a_rxd, a_inj_en, a_inj, a_tx_valid, a_tx_ready, a_tx_busy;
  logic [7:0] a_tx_data, a_rx_data;
  logic       a_rx_valid, a_rx_ready, a_rx_perr, a_rx_ferr, a_rx_ovf, a_ovf_clr;
  // instance B: 7E2 loopback
  logic       b_txd, b_tx_valid, b_tx_ready, b_tx_busy;
  logic [6:0] b_tx_data, b_rx_data;
  logic       b_rx_valid, b_rx_ready, b_rx_perr, b_rx_ferr, b_rx_ovf;
  // instance C: 8O1 with rxd driven by the bench
  logic       c_txd, c_rxd, c_tx_ready, c_tx_busy;
  logic [7:0] c_rx_data;
  logic       c_rx_valid, c_rx_ready, c_rx_perr, c_rx_ferr, c_rx_ovf;

  int   sel = 0;
  logic pop_rdy = 1'b0;
  logic m_valid, m_perr, m_ferr;
  logic [7:0] m_data;

  assign a_rxd      = a_inj_en ? a_inj : a_txd;
  assign a_rx_ready = (sel == 0) && pop_rdy;
  assign b_rx_ready = (sel == 1) && pop_rdy;
  assign c_rx_ready = (sel == 2) && pop_rdy;

  always_comb begin
    m_valid = a_rx_valid; m_data = a_rx_data; m_perr = a_rx_perr; m_ferr = a_rx_ferr;
    if (sel == 1) begin
      m_valid = b_rx_valid; m_data = {1'b0, b_rx_data}; m_perr = b_rx_perr; m_ferr = b_rx_ferr;
    end else if (sel == 2) begin
      m_valid = c_rx_valid; m_data = c_rx_data; m_perr = c_rx_perr; m_ferr = c_rx_ferr;
    end
  end

  uart_stream_model #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY(PAR_NONE), .STOP_BITS(1), .TX_DEPTH(16), .RX_DEPTH(4), .VERBOSE(0)) u_a (
    .clk(clk), .rst(rst), .rxd(a_rxd), .txd(a_txd), .tx_valid(a_tx_valid),
    .tx_data(a_tx_data), .tx_ready(a_tx_ready), .tx_busy(a_tx_busy),
    .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_data(a_rx_data),
    .rx_parity_err(a_rx_perr), .rx_frame_err(a_rx_ferr), .rx_overflow(a_rx_ovf),
    .overflow_clr(a_ovf_clr));

  uart_stream_model #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7),
    .PARITY(PAR_EVEN), .STOP_BITS(2), .TX_DEPTH(16), .RX_DEPTH(16), .VERBOSE(0)) u_b (
    .clk(clk), .rst(rst), .rxd(b_txd), .txd(b_txd), .tx_valid(b_tx_valid),
    .tx_data(b_tx_data), .tx_ready(b_tx_ready), .tx_busy(b_tx_busy),
    .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_data(b_rx_data),
    .rx_parity_err(b_rx_perr), .rx_frame_err(b_rx_ferr), .rx_overflow(b_rx_ovf),
    .overflow_clr(1'b0));

  uart_stream_model #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY(PAR_ODD), .STOP_BITS(1), .TX_DEPTH(16), .RX_DEPTH(16), .VERBOSE(0)) u_c (
    .clk(clk), .rst(rst), .rxd(c_rxd), .txd(c_txd), .tx_valid(1'b0),
    .tx_data(8'h00), .tx_ready(c_tx_ready), .tx_busy(c_tx_busy),
    .rx_valid(c_rx_valid), .rx_ready(c_rx_ready), .rx_data(c_rx_data),
    .rx_parity_err(c_rx_perr), .rx_frame_err(c_rx_ferr), .rx_overflow(c_rx_ovf),
    .overflow_clr(1'b0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] d);
    a_tx_valid = 1'b1; a_tx_data = d;
    @(negedge clk);
    a_tx_valid = 1'b0;
  endtask

  task automatic set_line(input int tgt, input logic v);
    if (tgt == 0) a_inj = v;
    else c_rxd = v;
  endtask

  task automatic drive(input int tgt, input logic [7:0] d, input bit use_par,
                       input logic p, input logic s);
    set_line(tgt, 1'b0); cyc(10);
    for (int i = 0; i < 8; i++) begin set_line(tgt, d[i]); cyc(10); end
    if (use_par) begin set_line(tgt, p); cyc(10); end
    set_line(tgt, s); cyc(10);
    set_line(tgt, 1'b1); cyc(10);
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    for (int i = 0; i < 600 && !m_valid; i++) @(negedge clk);
    check({tag, "_valid"}, 32'(m_valid), 1);
    if (m_valid && sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, 32'(m_data), 32'(e[7:0]));
      check({tag, "_perr"}, 32'(m_perr), 32'(e[8]));
      check({tag, "_ferr"}, 32'(m_ferr), 32'(e[9]));
      pop_rdy = 1'b1;
      @(negedge clk);
      pop_rdy = 1'b0;
    end
  endtask

  task automatic wait_a_idle(input string tag);
    for (int i = 0; i < 1000 && a_tx_busy; i++) @(negedge clk);
    check(tag, 32'(a_tx_busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] b_bits;
    a_inj_en = 1'b0; a_inj = 1'b1; a_tx_valid = 1'b0; a_tx_data = '0; a_ovf_clr = 1'b0;
    b_tx_valid = 1'b0; b_tx_data = '0; c_rxd = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);

    check("rst_a_txd", 32'(a_txd), 1);
    check("rst_a_busy", 32'(a_tx_busy), 0);
    check("rst_a_ready", 32'(a_tx_ready), 1);
    check("rst_a_rxv", 32'(a_rx_valid), 0);
    check("rst_a_ovf", 32'(a_rx_ovf), 0);
    check("rst_b_txd", 32'(b_txd), 1);
    check("rst_b_busy", 32'({b_tx_busy, b_tx_ready, b_rx_valid, b_rx_ovf}), 32'b0100);
    check("rst_c_state", 32'({c_txd, c_tx_busy, c_tx_ready, c_rx_valid, c_rx_ovf}), 32'b10100);

    // 8N1 loopback, three back-to-back bytes
    sel = 0;
    sb.push_back({2'b00, 8'hA5}); sb.push_back({2'b00, 8'h3C}); sb.push_back({2'b00, 8'hFF});
    send_a(8'hA5);
    check("lat_busy", 32'(a_tx_busy), 1);
    check("lat_txd_c1", 32'(a_txd), 1);
    send_a(8'h3C);
    check("lat_txd_c2", 32'(a_txd), 1);
    send_a(8'hFF);
    check("lat_txd_start", 32'(a_txd), 0);
    cyc(99);
    check("frame1_stop", 32'(a_txd), 1);
    cyc(1);
    check("frame2_start", 32'(a_txd), 0);
    pop_check("lb0");
    pop_check("lb1");
    pop_check("lb2");
    wait_a_idle("lb_idle");
    check("lb_rx_empty", 32'(a_rx_valid), 0);
    check("lb_txd_idle", 32'(a_txd), 1);

    // 7E2: 0x55 on the wire
    sel = 1;
    b_bits = 11'b11_0101_0101_0;
    b_tx_valid = 1'b1; b_tx_data = 7'h55;
    cyc(1);
    b_tx_valid = 1'b0;
    cyc(7);
    for (int k = 0; k < 11; k++) begin
      check($sformatf("b7e2_bit%0d", k), 32'(b_txd), 32'(b_bits[k]));
      cyc(10);
    end
    sb.push_back({2'b00, 8'h55});
    pop_check("b7e2");

    // 8O1 driven: odd parity bit of 0x01 is 0, of 0x03 is 1
    sel = 2;
    sb.push_back({2'b01, 8'h01});
    drive(2, 8'h01, 1'b1, 1'b1, 1'b1);
    pop_check("c_perr");
    sb.push_back({2'b00, 8'h01});
    drive(2, 8'h01, 1'b1, 1'b0, 1'b1);
    pop_check("c_ok01");
    sb.push_back({2'b00, 8'h03});
    drive(2, 8'h03, 1'b1, 1'b1, 1'b1);
    pop_check("c_ok03");

    // 8N1 framing error, then glitch followed by a clean frame
    sel = 0; a_inj_en = 1'b1;
    sb.push_back({2'b10, 8'h80});
    drive(0, 8'h80, 1'b0, 1'b0, 1'b0);
    pop_check("a_ferr");
    a_inj = 1'b0; cyc(3); a_inj = 1'b1;
    cyc(20);
    check("glitch_no_push", 32'(a_rx_valid), 0);
    sb.push_back({2'b00, 8'h42});
    drive(0, 8'h42, 1'b0, 1'b0, 1'b1);
    pop_check("a_after_glitch");
    a_inj_en = 1'b0;

    // overflow with RX_DEPTH 4
    send_a(8'h11); send_a(8'h22); send_a(8'h33); send_a(8'h44); send_a(8'h55);
    for (int i = 0; i < 4; i++) sb.push_back({2'b00, 8'(8'h11 * (i + 1))});
    cyc(450);
    check("ovf_before_5th", 32'(a_rx_ovf), 0);
    check("ovf_valid", 32'(a_rx_valid), 1);
    wait_a_idle("ovf_idle");
    cyc(2);
    check("ovf_set", 32'(a_rx_ovf), 1);
    a_ovf_clr = 1'b1; cyc(1); a_ovf_clr = 1'b0;
    check("ovf_clr", 32'(a_rx_ovf), 0);
    pop_check("ovf0");
    pop_check("ovf1");
    pop_check("ovf2");
    pop_check("ovf3");
    check("ovf_drained", 32'(a_rx_valid), 0);

    // reset in the middle of a TX frame
    send_a(8'h0F);
    cyc(34);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("mrst_txd", 32'(a_txd), 1);
    check("mrst_busy", 32'(a_tx_busy), 0);
    check("mrst_ready", 32'(a_tx_ready), 1);
    check("mrst_rxv", 32'(a_rx_valid), 0);
    cyc(150);
    check("mrst_no_partial", 32'(a_rx_valid), 0);
    check("mrst_txd_idle", 32'(a_txd), 1);
    sb.push_back({2'b00, 8'h0F});
    send_a(8'h0F);
    pop_check("mrst_again");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
